// File: rtl/cavlc_bit_buffer.sv
// CAVLC coeff_token bitstream front end: 64-bit MSB-first shift buffer with a 16-bit peek window.
// Optional byte-align consume is compiled in with `define CAVLC_BYTE_ALIGN_EN.
module cavlc_bit_buffer (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [31:0] InData,
  input  logic        InValid,
  output logic        InReady,
  output logic [15:0] Window,
  output logic        WindowValid,
  input  logic        ShiftEn,
  input  logic [4:0]  Shift,
  input  logic        Flush,
`ifdef CAVLC_BYTE_ALIGN_EN
  input  logic        AlignEn,
`endif
  output logic [6:0]  Level,
  output logic [31:0] BitCount,
  output logic        Error
);

  localparam int IN_W  = 32;
  localparam int WIN_W = 16;
  localparam int BUF_W = 64;

  logic [BUF_W-1:0] buf_r;
  logic [6:0]       level_r;
  logic [31:0]      bit_count_r;
  logic             error_r;
  logic             win_valid_r;
  logic             in_ready_r;

  logic [4:0]       consume_s;
  logic             illegal_s;
  logic             accept_s;
  logic [6:0]       level_shift_s;
  logic [6:0]       level_next_s;
  logic [BUF_W-1:0] buf_shift_s;
  logic [BUF_W-1:0] buf_next_s;
`ifdef CAVLC_BYTE_ALIGN_EN
  logic [2:0]       align_amt_s;
`endif

  // Consume request validation, shift-then-append next-state computation.
  always_comb begin
    consume_s = 5'd0;
    illegal_s = 1'b0;
`ifdef CAVLC_BYTE_ALIGN_EN
    align_amt_s = 3'd0 - bit_count_r[2:0];
    if (AlignEn && ShiftEn) begin
      illegal_s = 1'b1;
    end else if (AlignEn) begin
      if (level_r >= {4'd0, align_amt_s}) begin
        consume_s = {2'd0, align_amt_s};
      end else begin
        illegal_s = 1'b1;
      end
    end else if (ShiftEn) begin
`else
    if (ShiftEn) begin
`endif
      if ((level_r >= 7'd16) && (Shift <= 5'd16)) begin
        consume_s = Shift;
      end else begin
        illegal_s = 1'b1;
      end
    end else begin
      consume_s = 5'd0;
    end

    level_shift_s = level_r - {2'd0, consume_s};
    buf_shift_s   = buf_r << consume_s;
    accept_s      = InValid && in_ready_r;
    // Unfilled bits are always zero, so the new word can simply be OR-ed in at the post-shift fill.
    if (accept_s) begin
      buf_next_s   = buf_shift_s | ({InData, {(BUF_W-IN_W){1'b0}}} >> level_shift_s);
      level_next_s = level_shift_s + 7'd32;
    end else begin
      buf_next_s   = buf_shift_s;
      level_next_s = level_shift_s;
    end
  end

  // Buffer state; window/ready flags are registered from the next fill level.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      buf_r       <= {BUF_W{1'b0}};
      level_r     <= 7'd0;
      bit_count_r <= 32'd0;
      error_r     <= 1'b0;
      win_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else if (Flush) begin
      buf_r       <= {BUF_W{1'b0}};
      level_r     <= 7'd0;
      error_r     <= 1'b0;
      win_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      buf_r       <= buf_next_s;
      level_r     <= level_next_s;
      bit_count_r <= bit_count_r + {27'd0, consume_s};
      error_r     <= error_r | illegal_s;
      win_valid_r <= (level_next_s >= 7'd16);
      in_ready_r  <= (level_next_s <= 7'd32);
    end
  end

  assign Window      = buf_r[BUF_W-1 -: WIN_W];
  assign WindowValid = win_valid_r;
  assign InReady     = in_ready_r;
  assign Level       = level_r;
  assign BitCount    = bit_count_r;
  assign Error       = error_r;

endmodule
